// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-requester SDRAM arbiter: FSM state
// encoding, requester/owner encoding and the grant-selection rule.
package sdram_arbiter_pkg;

    // Command sequencer states; exactly one command is in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    // Which requester owns the in-flight command.
    typedef enum logic {
        OWN_SPI  = 1'b0,
        OWN_USER = 1'b1
    } owner_t;

    // SPI has priority unless the user request has been passed over
    // STARVE_LIMIT times in a row (starved), or SPI has nothing pending.
    function automatic owner_t pick_owner(
        input logic spi_valid,
        input logic user_valid,
        input logic starved
    );
        if (user_valid && (!spi_valid || starved)) begin
            return OWN_USER;
        end
        return OWN_SPI;
    endfunction

endpackage

// File: rtl/sdram_req_slot.sv
// One-entry holding register for a single requester. A request is
// captured only while the slot is empty; pulses that arrive while it is
// full are dropped. The slot empties when the arbiter signals completion,
// and completion wins over a same-cycle enable so the requester retries.
module sdram_req_slot #(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wr_data,
    input  logic                 clear,
    output logic                 valid,
    output logic                 slot_we,
    output logic [ADDR_BITS-1:0] slot_addr,
    output logic [7:0]           slot_wr_data
);

    logic capture;

    assign capture = enable && !valid && !clear;

    // Occupancy flag: completion has priority over a new capture.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values of its neighbours.
        if (reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end
    end

    // Request payload, loaded alongside the occupancy flag.
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset; valid alone qualifies it, so
        // clearing these wide registers would only add reset routing.
        if (capture) begin
            slot_we      <= we;
            slot_addr    <= addr;
            slot_wr_data <= wr_data;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates SPI and user-parser byte requests onto a single SDRAM
// controller command port. Each requester has its own holding slot; a
// single FSM issues one command at a time, waits out the controller's late
// busy assertion, then completes on busy falling (write) or on the read
// strobe (read). SPI has priority, bounded by a starvation counter that
// forces a user grant after STARVE_LIMIT consecutive SPI grants.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 spi_enable,
    input  logic                 spi_we,
    input  logic [ADDR_BITS-1:0] spi_addr,
    input  logic [7:0]           spi_wr_data,
    output logic [7:0]           spi_rd_data,
    output logic                 spi_rd_ready,
    output logic                 spi_busy,

    input  logic                 user_enable,
    input  logic                 user_we,
    input  logic [ADDR_BITS-1:0] user_addr,
    input  logic [7:0]           user_wr_data,
    output logic [7:0]           user_rd_data,
    output logic                 user_rd_ready,
    output logic                 user_busy,

    input  logic                 spi_refresh_inhibit,
    input  logic                 user_refresh_inhibit,

    output logic [ADDR_BITS-1:0] sd_addr,
    output logic [7:0]           sd_wr_data,
    output logic                 sd_we,
    output logic                 sd_enable,
    input  logic [7:0]           sd_rd_data,
    input  logic                 sd_rd_ready,
    input  logic                 sd_busy,
    output logic                 sd_refresh_inhibit
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t           state;
    owner_t               owner;
    owner_t               grant;
    logic                 cur_we;
    logic [STARVE_W-1:0]  starve_cnt;

    logic                 spi_valid;
    logic                 spi_slot_we;
    logic [ADDR_BITS-1:0] spi_slot_addr;
    logic [7:0]           spi_slot_wr_data;
    logic                 user_valid;
    logic                 user_slot_we;
    logic [ADDR_BITS-1:0] user_slot_addr;
    logic [7:0]           user_slot_wr_data;

    logic                 done;
    logic                 spi_clear;
    logic                 user_clear;

    // Busy is exactly "slot holds a request that has not completed yet".
    assign spi_busy  = spi_valid;
    assign user_busy = user_valid;

    sdram_req_slot #(.ADDR_BITS(ADDR_BITS)) u_spi_slot (
        .clk          (clk),
        .reset        (reset),
        .enable       (spi_enable),
        .we           (spi_we),
        .addr         (spi_addr),
        .wr_data      (spi_wr_data),
        .clear        (spi_clear),
        .valid        (spi_valid),
        .slot_we      (spi_slot_we),
        .slot_addr    (spi_slot_addr),
        .slot_wr_data (spi_slot_wr_data)
    );

    sdram_req_slot #(.ADDR_BITS(ADDR_BITS)) u_user_slot (
        .clk          (clk),
        .reset        (reset),
        .enable       (user_enable),
        .we           (user_we),
        .addr         (user_addr),
        .wr_data      (user_wr_data),
        .clear        (user_clear),
        .valid        (user_valid),
        .slot_we      (user_slot_we),
        .slot_addr    (user_slot_addr),
        .slot_wr_data (user_slot_wr_data)
    );

    // Completion decode and grant selection for the current cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        done       = 1'b0;
        spi_clear  = 1'b0;
        user_clear = 1'b0;
        grant      = pick_owner(spi_valid, user_valid, starve_cnt == STARVE_MAX);
        if (state == ST_WAIT) begin
            done = cur_we ? !sd_busy : sd_rd_ready;
        end
        if (done) begin
            spi_clear  = (owner == OWN_SPI);
            user_clear = (owner == OWN_USER);
        end
    end

    // Command sequencer with registered controller and read-return outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= OWN_SPI;
            cur_we        <= 1'b0;
            starve_cnt    <= '0;
            sd_enable     <= 1'b0;
            sd_we         <= 1'b0;
            sd_addr       <= '0;
            sd_wr_data    <= '0;
            spi_rd_ready  <= 1'b0;
            spi_rd_data   <= '0;
            user_rd_ready <= 1'b0;
            user_rd_data  <= '0;
        end else begin
            sd_enable     <= 1'b0;
            spi_rd_ready  <= 1'b0;
            user_rd_ready <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if ((spi_valid || user_valid) && !sd_busy) begin
                        sd_enable <= 1'b1;
                        owner     <= grant;
                        state     <= ST_ISSUE;
                        if (grant == OWN_USER) begin
                            sd_we      <= user_slot_we;
                            sd_addr    <= user_slot_addr;
                            sd_wr_data <= user_slot_wr_data;
                            cur_we     <= user_slot_we;
                            starve_cnt <= '0;
                        end else begin
                            sd_we      <= spi_slot_we;
                            sd_addr    <= spi_slot_addr;
                            sd_wr_data <= spi_slot_wr_data;
                            cur_we     <= spi_slot_we;
                            if (user_valid && starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + STARVE_W'(1);
                            end
                        end
                    end
                end

                // sd_enable is high for exactly this one cycle.
                ST_ISSUE: state <= ST_GAP;

                // Controller raises sd_busy late; do not sample it here.
                ST_GAP: state <= ST_WAIT;

                ST_WAIT: begin
                    if (done) begin
                        state <= ST_IDLE;
                        if (!cur_we) begin
                            if (owner == OWN_USER) begin
                                user_rd_data  <= sd_rd_data;
                                user_rd_ready <= 1'b1;
                            end else begin
                                spi_rd_data  <= sd_rd_data;
                                spi_rd_ready <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Refresh-inhibit hint: registered OR of both requesters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_refresh_inhibit <= 1'b0;
        end else begin
            sd_refresh_inhibit <= spi_refresh_inhibit | user_refresh_inhibit;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge; the bench plays the SDRAM controller itself.
module tb_sdram_arbiter;

    localparam int AB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_enable, spi_we;
    logic [AB-1:0] spi_addr;
    logic [7:0]    spi_wr_data;
    logic [7:0]    spi_rd_data;
    logic          spi_rd_ready, spi_busy;
    logic          user_enable, user_we;
    logic [AB-1:0] user_addr;
    logic [7:0]    user_wr_data;
    logic [7:0]    user_rd_data;
    logic          user_rd_ready, user_busy;
    logic          spi_refresh_inhibit, user_refresh_inhibit;
    logic [AB-1:0] sd_addr;
    logic [7:0]    sd_wr_data;
    logic          sd_we, sd_enable;
    logic [7:0]    sd_rd_data;
    logic          sd_rd_ready, sd_busy;
    logic          sd_refresh_inhibit;

    sdram_arbiter #(.ADDR_BITS(AB), .STARVE_LIMIT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .spi_enable           (spi_enable),
        .spi_we               (spi_we),
        .spi_addr             (spi_addr),
        .spi_wr_data          (spi_wr_data),
        .spi_rd_data          (spi_rd_data),
        .spi_rd_ready         (spi_rd_ready),
        .spi_busy             (spi_busy),
        .user_enable          (user_enable),
        .user_we              (user_we),
        .user_addr            (user_addr),
        .user_wr_data         (user_wr_data),
        .user_rd_data         (user_rd_data),
        .user_rd_ready        (user_rd_ready),
        .user_busy            (user_busy),
        .spi_refresh_inhibit  (spi_refresh_inhibit),
        .user_refresh_inhibit (user_refresh_inhibit),
        .sd_addr              (sd_addr),
        .sd_wr_data           (sd_wr_data),
        .sd_we                (sd_we),
        .sd_enable            (sd_enable),
        .sd_rd_data           (sd_rd_data),
        .sd_rd_ready          (sd_rd_ready),
        .sd_busy              (sd_busy),
        .sd_refresh_inhibit   (sd_refresh_inhibit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Event counters for strobes (each is a single-cycle pulse).
    int en_count       = 0;
    int spi_rdy_count  = 0;
    int user_rdy_count = 0;
    always @(posedge sd_enable)     en_count++;
    always @(posedge spi_rd_ready)  spi_rdy_count++;
    always @(posedge user_rd_ready) user_rdy_count++;

    // Command captured on the sd_enable cycle.
    logic          cmd_seen;
    logic          cmd_we;
    logic [AB-1:0] cmd_addr;
    logic [7:0]    cmd_wdata;

    // Outputs observed on the read-completion cycle.
    logic       o_spi_rdy, o_user_rdy, o_spi_busy, o_user_busy;
    logic [7:0] o_spi_data, o_user_data;

    int e0, r0, u0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance falling edges until sd_enable is seen (bounded).
    task automatic wait_cmd();
        cmd_seen = 1'b0;
        for (int i = 0; i < 20 && !cmd_seen; i++) begin
            @(negedge clk);
            if (sd_enable) begin
                cmd_seen  = 1'b1;
                cmd_we    = sd_we;
                cmd_addr  = sd_addr;
                cmd_wdata = sd_wr_data;
            end
        end
        check("sd_enable seen", 64'(cmd_seen), 64'd1);
    endtask

    // Called on the ISSUE cycle: busy up, two edges to WAIT, return a byte.
    task automatic serve_read(input logic [7:0] rdata, input logic keep_busy);
        sd_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sd_rd_ready = 1'b1;
        sd_rd_data  = rdata;
        @(negedge clk);
        sd_rd_ready = 1'b0;
        sd_rd_data  = 8'h00;
        o_spi_rdy   = spi_rd_ready;
        o_user_rdy  = user_rd_ready;
        o_spi_data  = spi_rd_data;
        o_user_data = user_rd_data;
        o_spi_busy  = spi_busy;
        o_user_busy = user_busy;
        if (!keep_busy) sd_busy = 1'b0;
    endtask

    // Called on the ISSUE cycle: busy up, then drop it once in WAIT.
    task automatic serve_write();
        sd_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sd_busy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        spi_enable = 0; spi_we = 0; spi_addr = '0; spi_wr_data = '0;
        user_enable = 0; user_we = 0; user_addr = '0; user_wr_data = '0;
        spi_refresh_inhibit = 1'b1; user_refresh_inhibit = 1'b1;
        sd_rd_data = '0; sd_rd_ready = 0; sd_busy = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst sd_enable", 64'(sd_enable), 64'd0);
        check("rst sd_addr", 64'(sd_addr), 64'd0);
        check("rst spi_busy", 64'(spi_busy), 64'd0);
        check("rst user_busy", 64'(user_busy), 64'd0);
        check("rst sd_refresh_inhibit", 64'(sd_refresh_inhibit), 64'd0);
        reset = 1'b0;
        user_refresh_inhibit = 1'b0;

        // Refresh inhibit is a registered OR.
        @(negedge clk);
        check("refinh spi only", 64'(sd_refresh_inhibit), 64'd1);
        spi_refresh_inhibit = 1'b0;
        @(negedge clk);
        check("refinh none", 64'(sd_refresh_inhibit), 64'd0);
        user_refresh_inhibit = 1'b1;
        @(negedge clk);
        check("refinh user only", 64'(sd_refresh_inhibit), 64'd1);
        user_refresh_inhibit = 1'b0;

        // Case 1: SPI read of 0x001234 returning 0xA5.
        e0 = en_count; u0 = user_rdy_count;
        spi_enable = 1; spi_we = 0; spi_addr = 32'h0000_1234;
        @(negedge clk);
        spi_enable = 0;
        check("c1 spi_busy set", 64'(spi_busy), 64'd1);
        check("c1 no sd_enable before latency", 64'(sd_enable), 64'd0);
        wait_cmd();
        check("c1 sd_we", 64'(cmd_we), 64'd0);
        check("c1 sd_addr", 64'(cmd_addr), 64'h1234);
        serve_read(8'hA5, 1'b0);
        check("c1 spi_rd_ready", 64'(o_spi_rdy), 64'd1);
        check("c1 spi_rd_data", 64'(o_spi_data), 64'hA5);
        check("c1 user_rd_ready", 64'(o_user_rdy), 64'd0);
        check("c1 spi_busy clear", 64'(o_spi_busy), 64'd0);
        @(negedge clk);
        check("c1 rd_ready one cycle", 64'(spi_rd_ready), 64'd0);
        check("c1 rd_data holds", 64'(spi_rd_data), 64'hA5);
        check("c1 one sd_enable", 64'(en_count - e0), 64'd1);
        check("c1 no user strobe", 64'(user_rdy_count - u0), 64'd0);

        // Case 2: user write 0x5A to 0x10.
        user_enable = 1; user_we = 1; user_addr = 32'h10; user_wr_data = 8'h5A;
        @(negedge clk);
        user_enable = 0;
        wait_cmd();
        check("c2 sd_we", 64'(cmd_we), 64'd1);
        check("c2 sd_addr", 64'(cmd_addr), 64'h10);
        check("c2 sd_wr_data", 64'(cmd_wdata), 64'h5A);
        sd_busy = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("c2 user_busy while sd_busy", 64'(user_busy), 64'd1);
        sd_busy = 0;
        @(negedge clk);
        check("c2 user_busy after sd_busy falls", 64'(user_busy), 64'd0);

        // Case 3: simultaneous SPI and user writes; SPI goes first.
        spi_enable = 1; spi_we = 1; spi_addr = 32'h20; spi_wr_data = 8'h11;
        user_enable = 1; user_we = 1; user_addr = 32'h30; user_wr_data = 8'h22;
        @(negedge clk);
        spi_enable = 0; user_enable = 0;
        check("c3 both busy", 64'({spi_busy, user_busy}), 64'b11);
        wait_cmd();
        check("c3 first addr spi", 64'(cmd_addr), 64'h20);
        check("c3 first data spi", 64'(cmd_wdata), 64'h11);
        serve_write();
        check("c3 busy after spi done", 64'({spi_busy, user_busy}), 64'b01);
        wait_cmd();
        check("c3 second addr user", 64'(cmd_addr), 64'h30);
        check("c3 second data user", 64'(cmd_wdata), 64'h22);
        serve_write();
        check("c3 user done", 64'(user_busy), 64'd0);

        // Case 4: user read waits through exactly 4 SPI grants.
        e0 = en_count;
        spi_enable = 1; spi_we = 0; spi_addr = 32'h100;
        user_enable = 1; user_we = 0; user_addr = 32'h200;
        @(negedge clk);
        spi_enable = 0; user_enable = 0;
        for (int k = 0; k < 4; k++) begin
            wait_cmd();
            check($sformatf("c4 spi grant %0d", k), 64'(cmd_addr), 64'(32'h100 + k));
            serve_read(8'h10 + 8'(k), 1'b1);
            // Re-request while the controller still holds busy so SPI is
            // pending again at the next arbitration.
            spi_enable = 1; spi_addr = 32'h100 + 32'(k + 1);
            @(negedge clk);
            spi_enable = 0;
            sd_busy = 0;
        end
        wait_cmd();
        check("c4 user wins after 4", 64'(cmd_addr), 64'h200);
        check("c4 spi still pending", 64'(spi_busy), 64'd1);
        serve_read(8'h77, 1'b0);
        check("c4 user_rd_ready", 64'(o_user_rdy), 64'd1);
        check("c4 user_rd_data", 64'(o_user_data), 64'h77);
        check("c4 spi_rd_ready quiet", 64'(o_spi_rdy), 64'd0);
        wait_cmd();
        check("c4 pending spi served", 64'(cmd_addr), 64'h104);
        serve_read(8'h3C, 1'b0);
        check("c4 spi_rd_data", 64'(o_spi_data), 64'h3C);
        check("c4 user_rd_data holds", 64'(o_user_data), 64'h77);
        check("c4 grant total", 64'(en_count - e0), 64'd6);

        // Case 6: second spi_enable while busy is dropped.
        @(negedge clk);
        e0 = en_count;
        spi_enable = 1; spi_we = 0; spi_addr = 32'h300;
        @(negedge clk);
        spi_addr = 32'h3FF;
        @(negedge clk);
        spi_enable = 0;
        check("c6 issue now", 64'(sd_enable), 64'd1);
        check("c6 first addr kept", 64'(sd_addr), 64'h300);
        serve_read(8'h5C, 1'b0);
        check("c6 spi_rd_data", 64'(o_spi_data), 64'h5C);
        repeat (6) @(negedge clk);
        check("c6 exactly one sd_enable", 64'(en_count - e0), 64'd1);
        check("c6 spi idle", 64'(spi_busy), 64'd0);

        // Case 5: reset during WAIT of a read.
        spi_refresh_inhibit = 1;
        spi_enable = 1; spi_we = 0; spi_addr = 32'h400;
        @(negedge clk);
        spi_enable = 0;
        wait_cmd();
        sd_busy = 1;
        @(negedge clk);
        @(negedge clk);
        check("c5 pre-reset sd_addr", 64'(sd_addr), 64'h400);
        reset = 1;
        #1;
        check("c5 rst sd_addr", 64'(sd_addr), 64'd0);
        check("c5 rst sd_we/en", 64'({sd_we, sd_enable}), 64'd0);
        check("c5 rst sd_wr_data", 64'(sd_wr_data), 64'd0);
        check("c5 rst busy", 64'({spi_busy, user_busy}), 64'd0);
        check("c5 rst spi_rd_data", 64'(spi_rd_data), 64'd0);
        check("c5 rst user_rd_data", 64'(user_rd_data), 64'd0);
        check("c5 rst rd_ready", 64'({spi_rd_ready, user_rd_ready}), 64'd0);
        check("c5 rst refresh_inhibit", 64'(sd_refresh_inhibit), 64'd0);
        @(negedge clk);
        reset = 0; spi_refresh_inhibit = 0; sd_busy = 0;
        e0 = en_count; r0 = spi_rdy_count; u0 = user_rdy_count;
        @(negedge clk);
        sd_rd_ready = 1; sd_rd_data = 8'hEE;
        @(negedge clk);
        sd_rd_ready = 0; sd_rd_data = 8'h00;
        @(negedge clk);
        check("c5 late rd ignored spi", 64'(spi_rdy_count - r0), 64'd0);
        check("c5 late rd ignored user", 64'(user_rdy_count - u0), 64'd0);
        check("c5 spi_rd_data stays 0", 64'(spi_rd_data), 64'd0);
        check("c5 no new command", 64'(en_count - e0), 64'd0);

        // Recovery: a fresh write after reset is issued normally.
        user_enable = 1; user_we = 1; user_addr = 32'h44; user_wr_data = 8'h99;
        @(negedge clk);
        user_enable = 0;
        wait_cmd();
        check("post-rst addr", 64'(cmd_addr), 64'h44);
        serve_write();
        check("post-rst user idle", 64'(user_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
